alu_seq_fsm: RTL

Parametrised successor to the single-shot ALU sequencer: sequences one ALU instruction per start pulse over the shared data bus. It reads the first operand from the register file into ALU latch 1, then reads the second operand from the register file or an immediate into latch 2. It executes for a configurable number of cycles and writes the result back to a separately addressed destination register. It sits between the instruction decoder and the register file / ALU / bus fabric.

---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/alu_seq_fsm.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the ALU instruction sequencer.
package alu_seq_pkg;

  localparam int unsigned DefAddrW = 6;
  localparam int unsigned DefOpW   = 4;
  localparam int unsigned DefDataW = 16;
  localparam int unsigned CntW     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StExec,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/alu_seq_fsm.sv
// Sequences one ALU instruction per start pulse: load A, optional load B, execute,
// write back, done. All outputs are decoded from the state and captured fields.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned OP_W        = DefOpW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              FSM_start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [OP_W-1:0]   opcode,
  input  logic              use_imm,
  input  logic              unary,
  input  logic [DATA_W-1:0] imm,
  output logic              bus_register_out_en,
  output logic              bus_register_input_en,
  output logic [ADDR_W-1:0] register_addr,
  output logic              imm_bus_out_en,
  output logic [DATA_W-1:0] imm_data,
  output logic              latched_bus1_en,
  output logic              latched_bus2_en,
  output logic              alu_bus_out_en,
  output logic [OP_W-1:0]   alu_control,
  output logic              busy,
  output logic              done
);

  localparam logic [CntW-1:0] ExecLoad = CntW'(EXEC_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d;
  logic [ADDR_W-1:0] src_b_q, src_b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic              use_imm_q, use_imm_d;
  logic              unary_q, unary_d;
  logic [DATA_W-1:0] imm_q, imm_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      opcode_q  <= '0;
      use_imm_q <= 1'b0;
      unary_q   <= 1'b0;
      imm_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      opcode_q  <= opcode_d;
      use_imm_q <= use_imm_d;
      unary_q   <= unary_d;
      imm_q     <= imm_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    dst_d     = dst_q;
    opcode_d  = opcode_q;
    use_imm_d = use_imm_q;
    unary_d   = unary_q;
    imm_d     = imm_q;
    unique case (state_q)
      StIdle: begin
        // Starts are only honoured here, so a start during DONE is dropped.
        if (FSM_start) begin
          state_d   = StLoadA;
          src_a_d   = src_a;
          src_b_d   = src_b;
          dst_d     = dst;
          opcode_d  = opcode;
          use_imm_d = use_imm;
          unary_d   = unary;
          imm_d     = imm;
        end
      end
      StLoadA: begin
        if (unary_q) begin
          state_d = StExec;
          cnt_d   = ExecLoad;
        end else begin
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        state_d = StExec;
        cnt_d   = ExecLoad;
      end
      StExec: begin
        if (cnt_q == '0) begin
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_register_out_en   = 1'b0;
    bus_register_input_en = 1'b0;
    register_addr         = '0;
    imm_bus_out_en        = 1'b0;
    latched_bus1_en       = 1'b0;
    latched_bus2_en       = 1'b0;
    alu_bus_out_en        = 1'b0;
    alu_control           = '0;
    done                  = 1'b0;
    unique case (state_q)
      StLoadA: begin
        bus_register_out_en = 1'b1;
        register_addr       = src_a_q;
        latched_bus1_en     = 1'b1;
      end
      StLoadB: begin
        if (use_imm_q) begin
          imm_bus_out_en = 1'b1;
        end else begin
          bus_register_out_en = 1'b1;
          register_addr       = src_b_q;
        end
        latched_bus2_en = 1'b1;
      end
      StExec: alu_control = opcode_q;
      StWrite: begin
        alu_control           = opcode_q;
        alu_bus_out_en        = 1'b1;
        bus_register_input_en = 1'b1;
        register_addr         = dst_q;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign imm_data = imm_q;

endmodule
